// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage sitting directly in front of main memory.
// Owns the PC, issues single-word reads, captures the returned word and offers it
// to decode through a valid/ready handshake. Redirects reload the PC and kill any
// in-flight or held instruction. Misaligned or out-of-window PCs raise a sticky fault.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch_count / stall_count outputs.
// Vectors use [0:N-1] ordering (bit 0 = MSB).
module fetch_unit #(
  parameter int unsigned            ADDRESS_SIZE  = 32,
  parameter int unsigned            DATA_SIZE     = 32,
  parameter logic [0:ADDRESS_SIZE-1] START_ADDRESS = 32'h8002_0000,
  parameter int unsigned            MEM_SIZE      = 1048578
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    redirect_valid,
  input  logic [0:ADDRESS_SIZE-1] redirect_pc,
  input  logic                    insn_ready,
  output logic                    insn_valid,
  output logic [0:DATA_SIZE-1]    insn,
  output logic [0:ADDRESS_SIZE-1] pc_out,
  output logic                    fetch_fault,
  output logic [0:ADDRESS_SIZE-1] mem_addr,
  output logic [0:1]              mem_acc_size,
  output logic                    mem_wren,
  output logic                    mem_en,
  input  logic [0:DATA_SIZE-1]    mem_d_out,
  input  logic                    mem_busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [0:31]             fetch_count,
  output logic [0:31]             stall_count
`endif
);

  typedef enum logic [1:0] {
    REQ,
    RESP,
    HOLD,
    FAULT
  } state_t;

  localparam logic [0:ADDRESS_SIZE-1] LAST_OFFSET = ADDRESS_SIZE'(MEM_SIZE - 4);
  localparam logic [0:ADDRESS_SIZE-1] WORD_BYTES  = ADDRESS_SIZE'(4);

  state_t                    state;
  logic [0:ADDRESS_SIZE-1]   pc;
  logic [0:ADDRESS_SIZE-1]   offset;
  logic                      ok;

  assign mem_addr     = pc;
  assign mem_acc_size = 2'b00;
  assign mem_wren     = 1'b0;

  // Current PC must be word aligned and its whole word must lie inside the window
  always_comb begin
    offset = pc - START_ADDRESS;
    ok     = (pc[ADDRESS_SIZE-2:ADDRESS_SIZE-1] == 2'b00) &&
             (pc >= START_ADDRESS) &&
             (offset <= LAST_OFFSET);
  end

  // Read request: from REQ, or from HOLD back-to-back with the accepted transfer
  always_comb begin
    mem_en = 1'b0;
    if (rst_n && !redirect_valid && ok && !mem_busy) begin
      case (state)
        REQ:     mem_en = 1'b1;
        HOLD:    mem_en = insn_ready;
        default: mem_en = 1'b0;
      endcase
    end
  end

  // Fetch FSM with registered handshake outputs; redirect overrides every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= REQ;
      pc          <= START_ADDRESS;
      insn        <= '0;
      pc_out      <= '0;
      insn_valid  <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (redirect_valid) begin
      pc          <= redirect_pc;
      insn_valid  <= 1'b0;
      fetch_fault <= 1'b0;
      state       <= REQ;
    end else begin
      case (state)
        REQ: begin
          if (!ok) begin
            fetch_fault <= 1'b1;
            state       <= FAULT;
          end else if (!mem_busy) begin
            state <= RESP;
          end
        end
        RESP: begin
          insn       <= mem_d_out;
          pc_out     <= pc;
          pc         <= pc + WORD_BYTES;
          insn_valid <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          if (insn_ready) begin
            insn_valid <= 1'b0;
            state      <= (ok && !mem_busy) ? RESP : REQ;
          end
        end
        FAULT: begin
          fetch_fault <= 1'b1;
          insn_valid  <= 1'b0;
        end
        default: state <= REQ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Transfer and stall counters; survive redirects, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (insn_valid && insn_ready && !redirect_valid)
        fetch_count <= fetch_count + 32'd1;
      if (insn_valid && !insn_ready)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus for fetch_unit with a transaction-level model
// (next expected instruction address) checked every cycle, plus literal checks.
module tb_fetch_unit;

  localparam longint unsigned START = 64'h8002_0000;
  localparam longint unsigned MEMSZ = 64'd1048578;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [0:31] redirect_pc;
  logic        insn_ready;
  logic        insn_valid;
  logic [0:31] insn;
  logic [0:31] pc_out;
  logic        fetch_fault;
  logic [0:31] mem_addr;
  logic [0:1]  mem_acc_size;
  logic        mem_wren;
  logic        mem_en;
  logic [0:31] mem_d_out;
  logic        mem_busy;
`ifdef FETCH_PERF_CNT_EN
  logic [0:31] fetch_count;
  logic [0:31] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .ADDRESS_SIZE (32),
    .DATA_SIZE    (32),
    .START_ADDRESS(32'h8002_0000),
    .MEM_SIZE     (1048578)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .insn_ready    (insn_ready),
    .insn_valid    (insn_valid),
    .insn          (insn),
    .pc_out        (pc_out),
    .fetch_fault   (fetch_fault),
    .mem_addr      (mem_addr),
    .mem_acc_size  (mem_acc_size),
    .mem_wren      (mem_wren),
    .mem_en        (mem_en),
    .mem_d_out     (mem_d_out),
    .mem_busy      (mem_busy)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [0:31] mem_word(input logic [0:31] a);
    if (a == 32'h8002_0000) return 32'h2008_0005;
    return a ^ 32'hC3C3_3C3C;
  endfunction

  function automatic bit in_range(input logic [0:31] a);
    longint unsigned x;
    x = 64'(a);
    return (x % 4 == 0) && (x >= START) && (x + 4 <= START + MEMSZ);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: word for the address requested at this edge is visible next cycle
  always @(posedge clk) begin
    if (mem_en) mem_d_out <= mem_word(mem_addr);
  end

  // Model state: address of the next instruction decode should see, plus counters
  logic [0:31] exp_pc;
  logic [0:31] n_xfer;
  logic [0:31] n_stall;

  // Per-cycle compare against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc  = 32'h8002_0000;
      n_xfer  = '0;
      n_stall = '0;
    end else begin
      chk("acc_size", 32'(mem_acc_size), 32'd0);
      chk("wren", 32'(mem_wren), 32'd0);
      if (insn_valid) begin
        chk("m_pc_out", pc_out, exp_pc);
        chk("m_insn", insn, mem_word(exp_pc));
      end
      if (fetch_fault) begin
        chk("m_fault_valid", 32'(insn_valid), 32'd0);
        chk("m_fault_range", 32'(in_range(exp_pc)), 32'd0);
      end
      if (mem_en) begin
        chk("m_en_busy", 32'(mem_busy), 32'd0);
        chk("m_en_redirect", 32'(redirect_valid), 32'd0);
        chk("m_addr", mem_addr, insn_valid ? exp_pc + 32'd4 : exp_pc);
        chk("m_addr_range", 32'(in_range(mem_addr)), 32'd1);
        if (insn_valid) chk("m_en_ready", 32'(insn_ready), 32'd1);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("m_fetch_count", fetch_count, n_xfer);
      chk("m_stall_count", stall_count, n_stall);
`endif
      if (insn_valid && !insn_ready) n_stall = n_stall + 32'd1;
      if (redirect_valid) begin
        exp_pc = redirect_pc;
      end else if (insn_valid && insn_ready) begin
        exp_pc = exp_pc + 32'd4;
        n_xfer = n_xfer + 32'd1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [0:31] a);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = a;
    cyc();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    insn_ready     = 1'b1;
    mem_busy       = 1'b0;
    mem_d_out      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(insn_valid), 32'd0);
    chk("rst_insn", insn, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);

    // First fetch after reset release and the back-to-back next one
    cyc(); rst_n = 1'b1;
    @(negedge clk);
    chk("t1_req_en", 32'(mem_en), 32'd1);
    chk("t1_req_addr", mem_addr, 32'h8002_0000);
    cyc(); @(negedge clk);
    chk("t1_resp_en", 32'(mem_en), 32'd0);
    chk("t1_resp_valid", 32'(insn_valid), 32'd0);
    cyc(); @(negedge clk);
    chk("t1_valid", 32'(insn_valid), 32'd1);
    chk("t1_insn", insn, 32'h2008_0005);
    chk("t1_pc_out", pc_out, 32'h8002_0000);
    chk("t1_next_en", 32'(mem_en), 32'd1);
    chk("t1_next_addr", mem_addr, 32'h8002_0004);
    cyc(); insn_ready = 1'b0;
    @(negedge clk);
    chk("t1_gap_valid", 32'(insn_valid), 32'd0);

    // Decode stalls for five cycles on the second instruction
    for (int i = 0; i < 5; i++) begin
      cyc(); @(negedge clk);
      chk("t2_valid", 32'(insn_valid), 32'd1);
      chk("t2_pc_out", pc_out, 32'h8002_0004);
      chk("t2_insn", insn, 32'h8002_0004 ^ 32'hC3C3_3C3C);
      chk("t2_mem_en", 32'(mem_en), 32'd0);
      chk("t2_pc_hold", mem_addr, 32'h8002_0008);
    end
    cyc(); insn_ready = 1'b1;
    @(negedge clk);
    chk("t2_release_en", 32'(mem_en), 32'd1);
    chk("t2_release_addr", mem_addr, 32'h8002_0008);
`ifdef FETCH_PERF_CNT_EN
    chk("t2_stall_count", stall_count, 32'd5);
    chk("t2_fetch_count", fetch_count, 32'd1);
`endif

    // Redirect during RESP drops the returned word
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h8002_0100;
    @(negedge clk);
    chk("t3_redir_en", 32'(mem_en), 32'd0);
    cyc(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3_req_addr", mem_addr, 32'h8002_0100);
    chk("t3_req_valid", 32'(insn_valid), 32'd0);
    cyc(); cyc();
    // Redirect in HOLD with insn_ready=1: held word must not be transferred
    redirect_valid = 1'b1; redirect_pc = 32'h8002_0200;
    @(negedge clk);
    chk("t3_valid", 32'(insn_valid), 32'd1);
    chk("t3_pc_out", pc_out, 32'h8002_0100);
    chk("t3_hold_redir_en", 32'(mem_en), 32'd0);
    cyc(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3_killed_valid", 32'(insn_valid), 32'd0);
    chk("t3_req2_addr", mem_addr, 32'h8002_0200);
`ifdef FETCH_PERF_CNT_EN
    chk("t3_fetch_count", fetch_count, 32'd2);
`endif
    cyc(); cyc(); mem_busy = 1'b1;
    @(negedge clk);
    chk("t3b_pc_out", pc_out, 32'h8002_0200);
    chk("t3b_busy_en", 32'(mem_en), 32'd0);
    cyc(); @(negedge clk);
    chk("t3b_req_busy_en", 32'(mem_en), 32'd0);
    cyc(); mem_busy = 1'b0;
    @(negedge clk);
    chk("t3b_req_en", 32'(mem_en), 32'd1);
    chk("t3b_req_addr", mem_addr, 32'h8002_0204);
    cyc(); cyc(); @(negedge clk);
    chk("t3b_pc_out2", pc_out, 32'h8002_0204);

    // Misaligned redirect faults without any read; redirect clears it
    redirect_to(32'h8002_0102);
    @(negedge clk);
    chk("t4_req_en", 32'(mem_en), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(); @(negedge clk);
      chk("t4_fault", 32'(fetch_fault), 32'd1);
      chk("t4_fault_en", 32'(mem_en), 32'd0);
    end
    redirect_to(32'h8002_0000);
    @(negedge clk);
    chk("t4_cleared", 32'(fetch_fault), 32'd0);
    chk("t4_restart_en", 32'(mem_en), 32'd1);

    // Last aligned word of the window, then the next PC faults
    redirect_to(32'h8011_FFFC);
    @(negedge clk);
    chk("t5_req_addr", mem_addr, 32'h8011_FFFC);
    cyc(); cyc(); @(negedge clk);
    chk("t5_valid", 32'(insn_valid), 32'd1);
    chk("t5_pc_out", pc_out, 32'h8011_FFFC);
    chk("t5_no_next_en", 32'(mem_en), 32'd0);
    cyc(); cyc(); @(negedge clk);
    chk("t5_fault", 32'(fetch_fault), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(); @(negedge clk);
      chk("t5_fault_en", 32'(mem_en), 32'd0);
    end
    // START+MEM_SIZE-4 is not word aligned in this window, so it faults directly
    redirect_to(32'h8011_FFFE);
    @(negedge clk);
    chk("t5b_req_en", 32'(mem_en), 32'd0);
    cyc(); @(negedge clk);
    chk("t5b_fault", 32'(fetch_fault), 32'd1);

    // Asynchronous reset in the middle of RESP
    redirect_to(32'h8002_0000);
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(insn_valid), 32'd0);
    chk("t6_insn", insn, 32'd0);
    chk("t6_pc_out", pc_out, 32'd0);
    chk("t6_fault", 32'(fetch_fault), 32'd0);
    chk("t6_mem_en", 32'(mem_en), 32'd0);
    cyc(); cyc(); rst_n = 1'b1;
    @(negedge clk);
    chk("t6_restart_addr", mem_addr, 32'h8002_0000);
    chk("t6_restart_en", 32'(mem_en), 32'd1);
    cyc(); cyc(); @(negedge clk);
    chk("t6_valid2", 32'(insn_valid), 32'd1);
    chk("t6_pc_out2", pc_out, 32'h8002_0000);
    chk("t6_insn2", insn, 32'h2008_0005);

    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
